// File: rtl/pet_pkg.sv
// Shared types and draw object codes for the virtual-pet sequencer.
// Imported by the arbiter and the top-level FSM.
package pet_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BG,
    S_PET,
    S_AGE,
    S_READY,
    S_ZS_DRAW,
    S_ZS_MOVE,
    S_ARB,
    S_BUBBLE_DRAW,
    S_BUBBLE_WAIT,
    S_ITEM_DRAW,
    S_ITEM_MOVE,
    S_DEAD_DRAW,
    S_OVER_DRAW,
    S_OVER_WAIT
  } state_e;

  localparam int SEL_BG          = 0;
  localparam int SEL_PET         = 1;
  localparam int SEL_AGE         = 2;
  localparam int SEL_ZS          = 3;
  localparam int SEL_OVER        = 4;
  localparam int SEL_DEAD        = 5;
  localparam int SEL_BUBBLE_BASE = 8;

  // Item codes follow the bubble codes, so they move with the channel count.
  function automatic int sel_item_base(input int n);
    return SEL_BUBBLE_BASE + n;
  endfunction

  function automatic logic is_draw(input state_e s);
    return (s == S_BG) || (s == S_PET) || (s == S_AGE) ||
           (s == S_ZS_DRAW) || (s == S_BUBBLE_DRAW) ||
           (s == S_ITEM_DRAW) || (s == S_DEAD_DRAW) ||
           (s == S_OVER_DRAW);
  endfunction

  function automatic logic is_move(input state_e s);
    return (s == S_ZS_MOVE) || (s == S_ITEM_MOVE);
  endfunction

endpackage

// File: rtl/need_arbiter.sv
// Need-channel arbiter: fixed priority (bit 0 first) or round-robin.
// Grant is combinational; rr pointer advances only when a grant is taken.
module need_arbiter
  import pet_pkg::*;
#(
  parameter int NUM_NEEDS = 5,
  parameter int ARB_MODE  = 0,
  parameter int AW        = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_NEEDS-1:0] req,
  input  logic                 adv,
  output logic [AW-1:0]        grant
);

  logic [AW-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW:0]   sum;
  logic [AW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_NEEDS; k++) begin
      if (ARB_MODE == 0) begin
        sum = (AW+1)'(k);
      end else begin
        sum = {1'b0, rr_ptr_q} + (AW+1)'(k);
        if (sum >= (AW+1)'(NUM_NEEDS))
          sum = sum - (AW+1)'(NUM_NEEDS);
      end
      idx = sum[AW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (adv)
      rr_ptr_d = (grant == AW'(NUM_NEEDS - 1)) ? '0
                                               : grant + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/pet_need_sequencer.sv
// Virtual-pet need sequencer: arbitrates need channels and drives
// the VGA draw/animate datapath with registered Moore outputs.
module pet_need_sequencer
  import pet_pkg::*;
#(
  parameter int                 NUM_NEEDS    = 5,
  parameter int                 ARB_MODE     = 0,
  parameter int                 TIMEOUT_W    = 24,
  parameter logic [TIMEOUT_W-1:0] BUBBLE_TICKS = 24'd5000000,
  parameter int                 DEATH_LIMIT  = 4,
  parameter int                 SEL_W        = 5,
  localparam int AW = (NUM_NEEDS > 1) ? $clog2(NUM_NEEDS) : 1,
  localparam int NW = $clog2(DEATH_LIMIT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 sleep,
  input  logic [NUM_NEEDS-1:0] need_req,
  input  logic [NUM_NEEDS-1:0] item_given,
  input  logic                 deceased,
  input  logic                 draw_done,
  input  logic                 move_done,
  output logic                 draw_en,
  output logic                 move_en,
  output logic [SEL_W-1:0]     draw_sel,
  output logic [AW-1:0]        active_need,
  output logic                 need_served,
  output logic [NW-1:0]        neglect_cnt,
  output logic                 game_over
);

  localparam logic [NW-1:0] LIM = NW'(DEATH_LIMIT);

  state_e                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   timer_q, timer_d;
  logic [NW-1:0]          neglect_q, neglect_d;
  logic [AW-1:0]          active_q, active_d;
  logic                   draw_en_q, draw_en_d;
  logic                   move_en_q, move_en_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   served_q, served_d;
  logic                   over_q, over_d;
  logic                   arb_adv;
  logic [AW-1:0]          arb_grant;
  logic                   draw_fire, move_fire;

  need_arbiter #(
    .NUM_NEEDS (NUM_NEEDS),
    .ARB_MODE  (ARB_MODE),
    .AW        (AW)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (need_req),
    .adv   (arb_adv),
    .grant (arb_grant)
  );

  assign draw_fire = draw_en_q & draw_done;
  assign move_fire = move_en_q & move_done;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    neglect_d = neglect_q;
    active_d  = active_q;
    served_d  = 1'b0;
    arb_adv   = 1'b0;
    unique case (state_q)
      S_IDLE: if (go) state_d = S_BG;
      S_BG: if (draw_fire)
        state_d = (deceased || neglect_q == LIM) ? S_OVER_DRAW : S_PET;
      S_PET: if (draw_fire) state_d = S_AGE;
      S_AGE: if (draw_fire) state_d = S_READY;
      S_READY: begin
        if (deceased)   state_d = S_DEAD_DRAW;
        else if (sleep) state_d = S_ZS_DRAW;
        else            state_d = S_ARB;
      end
      S_ZS_DRAW: if (draw_fire) state_d = S_ZS_MOVE;
      S_ZS_MOVE: if (move_fire) state_d = S_BG;
      S_ARB: begin
        if (|need_req) begin
          arb_adv  = 1'b1;
          active_d = arb_grant;
          timer_d  = '0;
          state_d  = S_BUBBLE_DRAW;
        end else begin
          state_d = S_READY;
        end
      end
      S_BUBBLE_DRAW: if (draw_fire) state_d = S_BUBBLE_WAIT;
      S_BUBBLE_WAIT: begin
        timer_d = timer_q + TIMEOUT_W'(1);
        // Item beats a same-cycle timeout, leaving neglect untouched.
        if (deceased) begin
          state_d = S_DEAD_DRAW;
        end else if (item_given[active_q]) begin
          state_d = S_ITEM_DRAW;
        end else if (timer_q == BUBBLE_TICKS - TIMEOUT_W'(1)) begin
          if (neglect_q != LIM) neglect_d = neglect_q + NW'(1);
          state_d = S_BG;
        end else if (!need_req[active_q]) begin
          state_d = S_BG;
        end
      end
      S_ITEM_DRAW: if (draw_fire) state_d = S_ITEM_MOVE;
      S_ITEM_MOVE: if (move_fire) begin
        served_d  = 1'b1;
        neglect_d = '0;
        state_d   = S_BG;
      end
      S_DEAD_DRAW: if (draw_fire) state_d = S_OVER_DRAW;
      S_OVER_DRAW: if (draw_fire) state_d = S_OVER_WAIT;
      S_OVER_WAIT: if (go) begin
        neglect_d = '0;
        state_d   = S_BG;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Enables drop for one cycle after a done so back-to-back
  // plots always present a fresh request edge.
  always_comb begin
    draw_en_d = is_draw(state_d) && !(draw_fire || move_fire);
    move_en_d = is_move(state_d) && !(draw_fire || move_fire);
    over_d    = (state_d == S_OVER_DRAW) || (state_d == S_OVER_WAIT);
    sel_d     = SEL_W'(SEL_BG);
    unique case (state_d)
      S_PET:                  sel_d = SEL_W'(SEL_PET);
      S_AGE:                  sel_d = SEL_W'(SEL_AGE);
      S_ZS_DRAW, S_ZS_MOVE:   sel_d = SEL_W'(SEL_ZS);
      S_BUBBLE_DRAW,
      S_BUBBLE_WAIT:
        sel_d = SEL_W'(SEL_BUBBLE_BASE) + SEL_W'(active_d);
      S_ITEM_DRAW,
      S_ITEM_MOVE:
        sel_d = SEL_W'(sel_item_base(NUM_NEEDS)) + SEL_W'(active_d);
      S_DEAD_DRAW:            sel_d = SEL_W'(SEL_DEAD);
      S_OVER_DRAW,
      S_OVER_WAIT:            sel_d = SEL_W'(SEL_OVER);
      default:                sel_d = SEL_W'(SEL_BG);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      neglect_q <= '0;
      active_q  <= '0;
      draw_en_q <= 1'b0;
      move_en_q <= 1'b0;
      sel_q     <= '0;
      served_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      neglect_q <= neglect_d;
      active_q  <= active_d;
      draw_en_q <= draw_en_d;
      move_en_q <= move_en_d;
      sel_q     <= sel_d;
      served_q  <= served_d;
      over_q    <= over_d;
    end
  end

  assign draw_en     = draw_en_q;
  assign move_en     = move_en_q;
  assign draw_sel    = sel_q;
  assign active_need = active_q;
  assign need_served = served_q;
  assign neglect_cnt = neglect_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_pet_need_sequencer.sv
// Directed bench: fixed-priority (u0) and round-robin (u1) sequencers
// share stimulus; a small datapath model answers draw/move requests.
module tb_pet_need_sequencer;

  logic       clk;
  logic       reset;
  logic       go;
  logic       sleep;
  logic [4:0] need_req;
  logic [4:0] item_given;
  logic       deceased;
  logic [1:0] draw_en, move_en, draw_done, move_done;
  logic [1:0] served, over;
  logic [4:0] sel0, sel1;
  logic [2:0] act0, act1, neg0, neg1;

  int checks = 0;
  int failures = 0;
  int dcnt [2];
  int mcnt [2];
  int exp_g [4] = '{0, 1, 0, 1};
  int cnt;

  pet_need_sequencer #(
    .NUM_NEEDS(5), .ARB_MODE(0), .TIMEOUT_W(24),
    .BUBBLE_TICKS(24'd10), .DEATH_LIMIT(4), .SEL_W(5)
  ) u0 (
    .clk(clk), .reset(reset), .go(go), .sleep(sleep),
    .need_req(need_req), .item_given(item_given),
    .deceased(deceased), .draw_done(draw_done[0]),
    .move_done(move_done[0]), .draw_en(draw_en[0]),
    .move_en(move_en[0]), .draw_sel(sel0),
    .active_need(act0), .need_served(served[0]),
    .neglect_cnt(neg0), .game_over(over[0])
  );

  pet_need_sequencer #(
    .NUM_NEEDS(5), .ARB_MODE(1), .TIMEOUT_W(24),
    .BUBBLE_TICKS(24'd10), .DEATH_LIMIT(4), .SEL_W(5)
  ) u1 (
    .clk(clk), .reset(reset), .go(go), .sleep(sleep),
    .need_req(need_req), .item_given(item_given),
    .deceased(deceased), .draw_done(draw_done[1]),
    .move_done(move_done[1]), .draw_en(draw_en[1]),
    .move_en(move_en[1]), .draw_sel(sel1),
    .active_need(act1), .need_served(served[1]),
    .neglect_cnt(neg1), .game_over(over[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: done pulses on the third cycle of a held request.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      draw_done[i] <= 1'b0;
      move_done[i] <= 1'b0;
      if (draw_en[i] && draw_done[i] !== 1'b1) begin
        if (dcnt[i] == 2) begin
          draw_done[i] <= 1'b1;
          dcnt[i] <= 0;
        end else dcnt[i] <= dcnt[i] + 1;
      end else dcnt[i] <= 0;
      if (move_en[i] && move_done[i] !== 1'b1) begin
        if (mcnt[i] == 2) begin
          move_done[i] <= 1'b1;
          mcnt[i] <= 0;
        end else mcnt[i] <= mcnt[i] + 1;
      end else mcnt[i] <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_st(input int u, input logic de, input logic me,
                         input logic [4:0] s, input int budget,
                         input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (u == 0) hit = ({draw_en[0], move_en[0], sel0} === {de, me, s});
      else        hit = ({draw_en[1], move_en[1], sel1} === {de, me, s});
      if (!hit) @(negedge clk);
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic wait_srv(input int u, input int budget,
                          input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      hit = (served[u] === 1'b1);
      if (!hit) @(negedge clk);
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic pulse_item(input logic [4:0] v);
    item_given = v;
    @(negedge clk);
    item_given = '0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; go = 1'b0; sleep = 1'b0; deceased = 1'b0;
    need_req = '0; item_given = '0;
    repeat (3) @(negedge clk);
    chk("rst_u0", {draw_en[0], move_en[0], sel0, act0,
                   served[0], neg0, over[0]}, 0);
    chk("rst_u1", {draw_en[1], move_en[1], sel1, act1,
                   served[1], neg1, over[1]}, 0);

    // Power-up sequence: BG, PET, AGE, then idle in READY/ARB.
    reset = 1'b0;
    pulse_go();
    wait_st(0, 1, 0, 5'd0, 10, "t1_bg");
    wait_st(0, 1, 0, 5'd1, 20, "t1_pet");
    wait_st(0, 1, 0, 5'd2, 20, "t1_age");
    repeat (8) @(negedge clk);
    chk("t1_ready", {draw_en[0], move_en[0], sel0, over[0]}, 0);

    // Fixed priority picks channel 2 of 10100.
    need_req = 5'b10100;
    wait_st(0, 1, 0, 5'd10, 20, "t2_bubble");
    chk("t2_active", act0, 2);
    wait_st(0, 0, 0, 5'd10, 20, "t2_wait");
    pulse_item(5'b00100);
    wait_st(0, 1, 0, 5'd15, 5, "t2_item_draw");
    wait_st(0, 0, 1, 5'd15, 20, "t2_item_move");
    wait_srv(0, 20, "t2_served");
    need_req = 5'b00011;
    @(negedge clk);
    chk("t2_served_pulse", served[0], 0);

    // Round-robin alternates 0,1,0,1; fixed priority stays on 0.
    for (int k = 0; k < 4; k++) begin
      wait_st(1, 1, 0, 5'(8 + exp_g[k]), 60, "t3_bubble");
      chk("t3_rr_grant", act1, exp_g[k]);
      chk("t3_fixed_grant", act0, 0);
      wait_st(1, 0, 0, 5'(8 + exp_g[k]), 20, "t3_wait");
      pulse_item(5'b00011);
      wait_srv(1, 40, "t3_served");
    end
    need_req = 5'b00010;

    // Ten-cycle bubble timeouts accumulate neglect up to the limit.
    for (int k = 0; k < 4; k++) begin
      wait_st(0, 0, 0, 5'd9, 60, "t4_wait");
      cnt = 0;
      while (sel0 === 5'd9 && draw_en[0] === 1'b0 && cnt < 50) begin
        cnt++;
        @(negedge clk);
      end
      chk("t4_wait_len", cnt, 10);
      chk("t4_neglect", neg0, k + 1);
    end
    wait_st(0, 1, 0, 5'd4, 20, "t4_over_draw");
    chk("t4_game_over", over[0], 1);
    wait_st(0, 0, 0, 5'd4, 20, "t4_over_wait");
    pulse_go();
    chk("t4_neglect_clr", neg0, 0);
    chk("t4_over_clr", over[0], 0);

    // Foreign item ignored; item on the timeout cycle wins.
    wait_st(0, 0, 0, 5'd9, 60, "t5_wait_a");
    wait_st(0, 1, 0, 5'd0, 20, "t5_timeout_bg");
    chk("t5_neglect1", neg0, 1);
    wait_st(0, 0, 0, 5'd9, 60, "t5_wait_b");
    pulse_item(5'b01000);
    chk("t5_foreign", {draw_en[0], move_en[0], sel0}, {2'b00, 5'd9});
    repeat (8) @(negedge clk);
    pulse_item(5'b00010);
    chk("t5_item_wins", {draw_en[0], move_en[0], sel0}, {2'b10, 5'd14});
    chk("t5_neglect_hold", neg0, 1);
    wait_srv(0, 40, "t5_served");
    chk("t5_neglect_zero", neg0, 0);

    // Reset in ITEM_MOVE aborts at once.
    need_req = 5'b00100;
    wait_st(0, 0, 0, 5'd10, 60, "t6_wait");
    pulse_item(5'b00100);
    wait_st(0, 0, 1, 5'd15, 30, "t6_item_move");
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_abort", {draw_en[0], move_en[0], sel0, act0,
                         served[0], neg0, over[0]}, 0);
    reset = 1'b0;
    pulse_go();

    // Death during a bubble wait goes DEAD then OVER.
    wait_st(0, 0, 0, 5'd10, 60, "t6_wait2");
    deceased = 1'b1;
    @(negedge clk);
    deceased = 1'b0;
    chk("t6_dead", {draw_en[0], move_en[0], sel0}, {2'b10, 5'd5});
    wait_st(0, 1, 0, 5'd4, 20, "t6_over");
    chk("t6_game_over", over[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
